// File: rtl/poly_eval_ctrl_pkg.sv
// rtl/poly_eval_ctrl_pkg.sv - state type and width helper for poly_eval_ctrl
package poly_eval_ctrl_pkg;

`include "poly_ctrl_defs.vh"

    typedef enum logic [2:0] {
        ST_IDLE  = `ST_IDLE,
        ST_LOAD  = `ST_LOAD,
        ST_ACCUM = `ST_ACCUM,
        ST_STORE = `ST_STORE,
        ST_DONE  = `ST_DONE
    } state_t;

    // Width of the coefficient index; a single-term polynomial still needs one bit.
    function automatic int sel_width(input int num_terms);
        return (num_terms > 1) ? $clog2(num_terms) : 1;
    endfunction

endpackage

// File: rtl/poly_ctrl_defs.vh
// rtl/poly_ctrl_defs.vh - shared state encodings for the polynomial sequencer and its datapath bench
`ifndef POLY_CTRL_DEFS_VH
`define POLY_CTRL_DEFS_VH

`define ST_IDLE  3'd0
`define ST_LOAD  3'd1
`define ST_ACCUM 3'd2
`define ST_STORE 3'd3
`define ST_DONE  3'd4

`endif

// File: rtl/term_counter.sv
// rtl/term_counter.sv - loadable down-counter that stops at zero
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset (count -> 0)
//   load      load count from load_val (wins over en)
//   load_val  value loaded when load=1
//   en        decrement by one; blocked once count reaches zero
//   count     current index
//   is_zero   count == 0
module term_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         is_zero
);

    assign is_zero = (count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !is_zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/poly_eval_ctrl.sv
// rtl/poly_eval_ctrl.sv - Horner-form polynomial evaluation sequencer
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     evaluation request (sampled in ST_IDLE, and ST_STORE when CONTINUOUS)
//   hold      datapath stall, only effective in ST_ACCUM
//   abort     synchronous cancel back to ST_IDLE
//   x_ld      load x operand register
//   sum_ld    accumulator <= sum*x + c[coef_sel]
//   sum_clr   clear accumulator
//   y_ld      result register <= accumulator
//   coef_sel  coefficient index of the current term
//   busy      any state other than ST_IDLE
//   done      one-cycle completion pulse
module poly_eval_ctrl
    import poly_eval_ctrl_pkg::*;
#(
    parameter  int NUM_TERMS  = 4,
    parameter  bit CONTINUOUS = 1'b0,
    localparam int SEL_W      = sel_width(NUM_TERMS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             hold,
    input  logic             abort,
    output logic             x_ld,
    output logic             sum_ld,
    output logic             sum_clr,
    output logic             y_ld,
    output logic [SEL_W-1:0] coef_sel,
    output logic             busy,
    output logic             done
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_TERMS - 1);

    state_t           state;
    state_t           state_nxt;
    logic             chain_q;
    logic             chain_nxt;
    logic [SEL_W-1:0] index;
    logic             idx_zero;
    logic             idx_load;
    logic             idx_dec;

    term_counter #(
        .W (SEL_W)
    ) u_term_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (idx_load),
        .load_val (LAST_IDX),
        .en       (idx_dec),
        .count    (index),
        .is_zero  (idx_zero)
    );

    // chain_q marks a ST_LOAD entered straight from ST_STORE, so the done
    // pulse for the previous evaluation lands in that LOAD cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            chain_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            chain_q <= chain_nxt;
        end
    end

    // Next state: abort beats hold, hold beats start.
    always_comb begin
        state_nxt = state;
        chain_nxt = 1'b0;
        idx_load  = 1'b0;
        idx_dec   = 1'b0;
        if (abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    idx_load  = 1'b1;
                    state_nxt = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (!hold) begin
                        if (idx_zero) begin
                            state_nxt = ST_STORE;
                        end else begin
                            idx_dec = 1'b1;
                        end
                    end
                end
                ST_STORE: begin
                    if (CONTINUOUS && start) begin
                        state_nxt = ST_LOAD;
                        chain_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode; hold -> sum_ld is the only combinational input path.
    always_comb begin
        x_ld     = 1'b0;
        sum_ld   = 1'b0;
        sum_clr  = 1'b0;
        y_ld     = 1'b0;
        coef_sel = '0;
        done     = 1'b0;
        busy     = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                sum_clr = 1'b1;
            end
            ST_LOAD: begin
                x_ld    = 1'b1;
                sum_clr = 1'b1;
                done    = chain_q;
            end
            ST_ACCUM: begin
                sum_ld   = ~hold;
                coef_sel = index;
            end
            ST_STORE: begin
                y_ld = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                sum_clr = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_poly_eval_ctrl.sv
// tb/tb_poly_eval_ctrl.sv - self-checking bench for poly_eval_ctrl
module tb_poly_eval_ctrl;

    localparam int X_VAL = 2;

    typedef struct {
        logic       start;
        logic       hold;
        logic       abort;
        logic       push;
        logic [5:0] flags;  // {x_ld, sum_ld, sum_clr, y_ld, busy, done}
        logic [7:0] sel;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] st;
    logic [3:0] hd;
    logic [3:0] ab;
    logic [3:0] o_xld, o_sld, o_sclr, o_yld, o_busy, o_done;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic       sel2;
    logic [2:0] sel3;
    logic [7:0] sel_ext [4];

    vec_t vecs[$];
    int   sb[$];
    int   n_checks;
    int   n_fail;
    int   coef [4];
    int   x_r, sum_r, y_r;

    // inst 0: N=4; inst 1: N=3 continuous; inst 2: N=1; inst 3: N=5
    poly_eval_ctrl #(.NUM_TERMS(4), .CONTINUOUS(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(st[0]), .hold(hd[0]), .abort(ab[0]),
        .x_ld(o_xld[0]), .sum_ld(o_sld[0]), .sum_clr(o_sclr[0]), .y_ld(o_yld[0]),
        .coef_sel(sel0), .busy(o_busy[0]), .done(o_done[0]));
    poly_eval_ctrl #(.NUM_TERMS(3), .CONTINUOUS(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(st[1]), .hold(hd[1]), .abort(ab[1]),
        .x_ld(o_xld[1]), .sum_ld(o_sld[1]), .sum_clr(o_sclr[1]), .y_ld(o_yld[1]),
        .coef_sel(sel1), .busy(o_busy[1]), .done(o_done[1]));
    poly_eval_ctrl #(.NUM_TERMS(1), .CONTINUOUS(1'b0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(st[2]), .hold(hd[2]), .abort(ab[2]),
        .x_ld(o_xld[2]), .sum_ld(o_sld[2]), .sum_clr(o_sclr[2]), .y_ld(o_yld[2]),
        .coef_sel(sel2), .busy(o_busy[2]), .done(o_done[2]));
    poly_eval_ctrl #(.NUM_TERMS(5), .CONTINUOUS(1'b0)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(st[3]), .hold(hd[3]), .abort(ab[3]),
        .x_ld(o_xld[3]), .sum_ld(o_sld[3]), .sum_clr(o_sclr[3]), .y_ld(o_yld[3]),
        .coef_sel(sel3), .busy(o_busy[3]), .done(o_done[3]));

    always_comb begin
        sel_ext[0] = {6'd0, sel0};
        sel_ext[1] = {6'd0, sel1};
        sel_ext[2] = {7'd0, sel2};
        sel_ext[3] = {5'd0, sel3};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model for inst 0, driven by the controller strobes.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r   <= 0;
            sum_r <= 0;
            y_r   <= 0;
        end else begin
            if (o_xld[0]) x_r <= X_VAL;
            if (o_sclr[0]) sum_r <= 0;
            else if (o_sld[0]) sum_r <= sum_r * x_r + coef[sel_ext[0]];
            if (o_yld[0]) y_r <= sum_r;
        end
    end

    // Scoreboard pop on each completion pulse of inst 0.
    always @(negedge clk) begin
        #2;
        if (reset_n && o_done[0]) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: got done with y=%0d, required no done", y_r);
            end else begin
                int exp_y;
                exp_y = sb.pop_front();
                if (y_r != exp_y) begin
                    n_fail++;
                    $display("FAIL sb_y: got y=%0d, required %0d", y_r, exp_y);
                end
            end
        end
    end

    // Direct power-series sum, independent of the Horner order.
    function automatic int poly_ref(input int x);
        int acc;
        int p;
        acc = 0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            acc += coef[i] * p;
            p *= x;
        end
        return acc;
    endfunction

    function automatic logic [5:0] flags_of(input int k);
        return {o_xld[k], o_sld[k], o_sclr[k], o_yld[k], o_busy[k], o_done[k]};
    endfunction

    task automatic add(input logic s, input logic h, input logic a, input logic p,
                       input logic xl, input logic sl, input logic sc, input logic yl,
                       input int sel, input logic bz, input logic dn);
        vec_t v;
        v.start = s;
        v.hold  = h;
        v.abort = a;
        v.push  = p;
        v.flags = {xl, sl, sc, yl, bz, dn};
        v.sel   = 8'(sel);
        vecs.push_back(v);
    endtask

    task automatic check_outs(input int k, input string name, input logic [5:0] ef, input logic [7:0] es);
        n_checks++;
        if ({flags_of(k), sel_ext[k]} !== {ef, es}) begin
            n_fail++;
            $display("FAIL %s: got flags=%b sel=%0d, required flags=%b sel=%0d",
                     name, flags_of(k), sel_ext[k], ef, es);
        end
    endtask

    // One row per clock cycle: inputs on the falling edge, outputs checked 1ns later.
    task automatic run_vecs(input int k, input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            st[k] = vecs[i].start;
            hd[k] = vecs[i].hold;
            ab[k] = vecs[i].abort;
            if (vecs[i].push) sb.push_back(poly_ref(X_VAL));
            #1;
            check_outs(k, $sformatf("%s_c%0d", name, i), vecs[i].flags, vecs[i].sel);
        end
        @(negedge clk);
        st[k] = 1'b0;
        hd[k] = 1'b0;
        ab[k] = 1'b0;
        vecs.delete();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        coef     = '{1, 2, 3, 4};
        st = '0;
        hd = '0;
        ab = '0;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) check_outs(k, $sformatf("reset_inst%0d", k), 6'b001000, 8'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset asserted mid-ACCUM takes effect without a clock edge.
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        @(negedge clk); #1;
        check_outs(0, "pre_reset_accum", 6'b010010, 8'd3);
        reset_n = 1'b0;
        #1;
        check_outs(0, "async_reset", 6'b001000, 8'd0);
        @(negedge clk); reset_n = 1'b1;

        // Basic N=4, start while busy ignored.
        add(1,0,0,1, 0,0,1,0, 0,0,0);
        add(0,0,0,0, 1,0,1,0, 0,1,0);
        add(0,0,0,0, 0,1,0,0, 3,1,0);
        add(1,0,0,0, 0,1,0,0, 2,1,0);
        add(0,0,0,0, 0,1,0,0, 1,1,0);
        add(0,0,0,0, 0,1,0,0, 0,1,0);
        add(0,0,0,0, 0,0,0,1, 0,1,0);
        add(0,0,0,0, 0,0,0,0, 0,1,1);
        add(0,0,0,0, 0,0,1,0, 0,0,0);
        run_vecs(0, "basic");

        // Hold two cycles at coef_sel=2; hold in IDLE/LOAD/STORE ignored.
        add(1,1,0,1, 0,0,1,0, 0,0,0);
        add(0,1,0,0, 1,0,1,0, 0,1,0);
        add(0,0,0,0, 0,1,0,0, 3,1,0);
        add(0,1,0,0, 0,0,0,0, 2,1,0);
        add(0,1,0,0, 0,0,0,0, 2,1,0);
        add(0,0,0,0, 0,1,0,0, 2,1,0);
        add(0,0,0,0, 0,1,0,0, 1,1,0);
        add(0,0,0,0, 0,1,0,0, 0,1,0);
        add(0,1,0,0, 0,0,0,1, 0,1,0);
        add(0,0,0,0, 0,0,0,0, 0,1,1);
        add(0,0,0,0, 0,0,1,0, 0,0,0);
        run_vecs(0, "hold");

        // Abort (with hold) at coef_sel=1, then a fresh start completes.
        add(1,0,0,0, 0,0,1,0, 0,0,0);
        add(0,0,0,0, 1,0,1,0, 0,1,0);
        add(0,0,0,0, 0,1,0,0, 3,1,0);
        add(0,0,0,0, 0,1,0,0, 2,1,0);
        add(0,1,1,0, 0,0,0,0, 1,1,0);
        add(0,0,0,0, 0,0,1,0, 0,0,0);
        add(1,0,0,1, 0,0,1,0, 0,0,0);
        add(0,0,0,0, 1,0,1,0, 0,1,0);
        add(0,0,0,0, 0,1,0,0, 3,1,0);
        add(0,0,0,0, 0,1,0,0, 2,1,0);
        add(0,0,0,0, 0,1,0,0, 1,1,0);
        add(0,0,0,0, 0,1,0,0, 0,1,0);
        add(0,0,0,0, 0,0,0,1, 0,1,0);
        add(0,0,0,0, 0,0,0,0, 0,1,1);
        add(0,0,0,0, 0,0,1,0, 0,0,0);
        run_vecs(0, "abort");

        // CONTINUOUS N=3: chained evaluations, done with each chained x_ld.
        add(1,0,0,0, 0,0,1,0, 0,0,0);
        add(1,0,0,0, 1,0,1,0, 0,1,0);
        add(1,0,0,0, 0,1,0,0, 2,1,0);
        add(1,0,0,0, 0,1,0,0, 1,1,0);
        add(1,0,0,0, 0,1,0,0, 0,1,0);
        add(1,0,0,0, 0,0,0,1, 0,1,0);
        add(1,0,0,0, 1,0,1,0, 0,1,1);
        add(1,0,0,0, 0,1,0,0, 2,1,0);
        add(1,0,0,0, 0,1,0,0, 1,1,0);
        add(1,0,0,0, 0,1,0,0, 0,1,0);
        add(1,0,0,0, 0,0,0,1, 0,1,0);
        add(0,0,0,0, 1,0,1,0, 0,1,1);
        add(0,0,0,0, 0,1,0,0, 2,1,0);
        add(0,0,0,0, 0,1,0,0, 1,1,0);
        add(0,0,0,0, 0,1,0,0, 0,1,0);
        add(0,0,0,0, 0,0,0,1, 0,1,0);
        add(0,0,0,0, 0,0,0,0, 0,1,1);
        add(0,0,0,0, 0,0,1,0, 0,0,0);
        run_vecs(1, "cont");

        // N=1: a single ACCUM cycle at index 0.
        add(1,0,0,0, 0,0,1,0, 0,0,0);
        add(0,0,0,0, 1,0,1,0, 0,1,0);
        add(0,0,0,0, 0,1,0,0, 0,1,0);
        add(0,0,0,0, 0,0,0,1, 0,1,0);
        add(0,0,0,0, 0,0,0,0, 0,1,1);
        add(0,0,0,0, 0,0,1,0, 0,0,0);
        run_vecs(2, "n1");

        // N=5: index 4..0, start during ACCUM and DONE ignored.
        add(1,0,0,0, 0,0,1,0, 0,0,0);
        add(0,0,0,0, 1,0,1,0, 0,1,0);
        add(0,0,0,0, 0,1,0,0, 4,1,0);
        add(0,0,0,0, 0,1,0,0, 3,1,0);
        add(1,0,0,0, 0,1,0,0, 2,1,0);
        add(0,0,0,0, 0,1,0,0, 1,1,0);
        add(0,0,0,0, 0,1,0,0, 0,1,0);
        add(0,0,0,0, 0,0,0,1, 0,1,0);
        add(1,0,0,0, 0,0,0,0, 0,1,1);
        add(0,0,0,0, 0,0,1,0, 0,0,0);
        add(0,0,0,0, 0,0,1,0, 0,0,0);
        run_vecs(3, "n5");

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending results, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
